// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: write-data source select, load type
// encodings and the program counter reset vector.
package mips_pkg;

    // Write-data source for the W-stage register file write.
    typedef enum logic [1:0] {
        WD_AO   = 2'd0,   // ALU result
        WD_LOAD = 2'd1,   // extended data-memory word
        WD_LINK = 2'd2,   // return address for jal/jalr (pc4 + 4)
        WD_AO_X = 2'd3    // alias of WD_AO
    } wd_sel_e;

    // Load type; codes 5-7 behave like lw.
    typedef enum logic [2:0] {
        LD_LW  = 3'd0,
        LD_LB  = 3'd1,
        LD_LBU = 3'd2,
        LD_LH  = 3'd3,
        LD_LHU = 3'd4
    } ld_type_e;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;

    // Sign-extend a byte to a word.
    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    // Sign-extend a halfword to a word.
    function automatic logic [31:0] sext16(input logic [15:0] h);
        return {{16{h[15]}}, h};
    endfunction

endpackage

// File: rtl/load_ext.sv
// Load data extension: picks the addressed byte or halfword out of the raw
// memory word and sign- or zero-extends it to 32 bits.
module load_ext
    import mips_pkg::*;
(
    input  logic [31:0] dr,
    input  logic [1:0]  ao,
    input  logic [2:0]  ld_type,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Select the byte addressed by ao and the halfword addressed by ao[1].
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned and no latch is inferred.
        byte_v = dr[7:0];
        case (ao)
            2'd1:    byte_v = dr[15:8];
            2'd2:    byte_v = dr[23:16];
            2'd3:    byte_v = dr[31:24];
            default: byte_v = dr[7:0];
        endcase
        half_v = ao[1] ? dr[31:16] : dr[15:0];
    end

    // Extend the selected lane according to the load type.
    always_comb begin
        data = dr;
        case (ld_type)
            LD_LB:   data = sext8(byte_v);
            LD_LBU:  data = {24'd0, byte_v};
            LD_LH:   data = sext16(half_v);
            LD_LHU:  data = {16'd0, half_v};
            default: data = dr;
        endcase
    end

endmodule

// File: rtl/wb_grf.sv
// Write-back stage general register file: 32 x 32-bit registers with
// write-through bypass on both read ports and a one-cycle-delayed commit log.
module wb_grf
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        w_en,
    input  logic [4:0]  A3_34,
    input  logic [31:0] AO_34,
    input  logic [31:0] DR_34,
    input  logic [31:0] pc4_34,
    input  logic [31:0] pc_34,
    input  logic [1:0]  wd_sel,
    input  logic [2:0]  ld_type,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic        log_valid,
    output logic [31:0] log_pc,
    output logic [4:0]  log_reg,
    output logic [31:0] log_data
);

    logic [31:0] regs [32];
    logic [31:0] ld_data;
    logic [31:0] wd;
    logic        wr_fire;

    load_ext u_load_ext (
        .dr      (DR_34),
        .ao      (AO_34[1:0]),
        .ld_type (ld_type),
        .data    (ld_data)
    );

    // A write happens only out of reset and never to register 0; the same
    // qualifier gates the bypass so reset also disables forwarding.
    assign wr_fire = reset && w_en && (A3_34 != 5'd0);

    // Choose the write data source; the link address wraps at 32 bits.
    always_comb begin
        wd = AO_34;
        case (wd_sel)
            WD_LOAD: wd = ld_data;
            WD_LINK: wd = pc4_34 + 32'd4;
            default: wd = AO_34;
        endcase
    end

    // Register array update with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the whole array is cleared on reset, which forces it into flops rather than a RAM macro; the architecture requires every register to read 0 after reset.
            for (int i = 0; i < 32; i++) begin
                // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
                regs[i] <= '0;
            end
        end else if (wr_fire) begin
            regs[A3_34] <= wd;
        end
    end

    // rs read port: reset forces 0, register 0 is hardwired, same-cycle write wins.
    always_comb begin
        rs_data = '0;
        if (reset && rs_addr != 5'd0) begin
            if (wr_fire && rs_addr == A3_34) rs_data = wd;
            else                             rs_data = regs[rs_addr];
        end
    end

    // rt read port: same rules as rs, evaluated independently.
    always_comb begin
        rt_data = '0;
        if (reset && rt_addr != 5'd0) begin
            if (wr_fire && rt_addr == A3_34) rt_data = wd;
            else                             rt_data = regs[rt_addr];
        end
    end

    // Commit log: valid pulses for one cycle after a write, fields hold otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            log_valid <= 1'b0;
            log_pc    <= PC_RESET;
            log_reg   <= '0;
            log_data  <= '0;
        end else begin
            log_valid <= wr_fire;
            if (wr_fire) begin
                log_pc   <= pc_34;
                log_reg  <= A3_34;
                log_data <= wd;
            end
        end
    end

endmodule
